// File: rtl/note_tick_pkg.sv
// rtl/note_tick_pkg.sv - shared octave table, note width and FSM states for note_tick_voices
package note_tick_pkg;

  localparam int NOTE_W = 7;

  // Half-period in sample ticks for the lowest octave, notes 0..11
  localparam logic [23:0] OCTAVE_TICKS [12] = '{
    24'd23889, 24'd22548, 24'd21282, 24'd20088,
    24'd18960, 24'd17896, 24'd16892, 24'd15944,
    24'd15049, 24'd14204, 24'd13407, 24'd12654
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    LOAD   = 2'd2
  } state_t;

  // Table read that stays defined for the unused remainder codes 12..15
  function automatic logic [23:0] octave_lookup(input logic [3:0] idx);
    logic [23:0] val;
    val = '0;
    if (idx < 4'd12) begin
      val = OCTAVE_TICKS[idx];
    end
    return val;
  endfunction

endpackage

// File: rtl/note_voice_counter.sv
// rtl/note_voice_counter.sv - one voice: period register, phase counter, square and edge outputs
module note_voice_counter
  import note_tick_pkg::*;
#(
  parameter int TICK_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  input  logic                  load,
  input  logic [TICK_WIDTH-1:0] load_ticks,
  input  logic                  note_off,
  output logic                  active,
  output logic                  square,
  output logic                  toggle,
  output logic [TICK_WIDTH-1:0] ticks
);

  logic [TICK_WIDTH-1:0] phase;
  logic                  terminal;

  // >= rather than == so a period shortened under a running phase wraps at once
  assign terminal = (phase >= (ticks - TICK_WIDTH'(1)));

  // Load/retrigger beats note-off beats counting; a tick on the load cycle is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active <= 1'b0;
      square <= 1'b0;
      toggle <= 1'b0;
      phase  <= '0;
      ticks  <= '0;
    end else begin
      toggle <= 1'b0;
      if (load) begin
        ticks  <= load_ticks;
        phase  <= '0;
        square <= 1'b0;
        active <= 1'b1;
      end else if (note_off) begin
        active <= 1'b0;
        square <= 1'b0;
        phase  <= '0;
      end else if (active && sample_tick) begin
        if (terminal) begin
          phase  <= '0;
          square <= ~square;
          toggle <= 1'b1;
        end else begin
          phase <= phase + TICK_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/note_tick_voices.sv
// rtl/note_tick_voices.sv - multi-voice note to half-period lookup with per-voice square generators
module note_tick_voices
  import note_tick_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int TICK_WIDTH = 24,
  parameter int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             sampleTick,
  input  logic                             cmdValid,
  output logic                             cmdReady,
  input  logic                             cmdNoteOn,
  input  logic [VOICE_W-1:0]               cmdVoice,
  input  logic [NOTE_W-1:0]                cmdNote,
  output logic [NUM_VOICES-1:0]            voiceActive,
  output logic [NUM_VOICES-1:0]            voiceSquare,
  output logic [NUM_VOICES-1:0]            voiceEdge,
  output logic [NUM_VOICES*TICK_WIDTH-1:0] voiceTicks
);

  localparam logic [VOICE_W:0] VOICE_LIMIT = (VOICE_W+1)'(NUM_VOICES);

  state_t               state;
  state_t               next_state;
  logic [NOTE_W-1:0]    rem;
  logic [3:0]           oct;
  logic [VOICE_W-1:0]   cur_voice;
  logic                 accept;
  logic                 voice_ok;
  logic                 start;
  logic                 stop;
  logic [23:0]          base_ticks;
  logic [TICK_WIDTH-1:0] load_ticks;

  assign accept   = cmdValid && cmdReady;
  assign voice_ok = ({1'b0, cmdVoice} < VOICE_LIMIT);

  // Remainder indexes the octave table, quotient is the octave shift
  assign base_ticks = octave_lookup(rem[3:0]);
  assign load_ticks = TICK_WIDTH'(base_ticks >> oct);

  // Next state plus the one-cycle start/stop strobes for an accepted command
  always_comb begin
    next_state = state;
    start      = 1'b0;
    stop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept && voice_ok) begin
          if (cmdNoteOn) begin
            start      = 1'b1;
            next_state = DIVIDE;
          end else begin
            stop = 1'b1;
          end
        end
      end
      DIVIDE: begin
        if (rem < NOTE_W'(12)) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register; ready is registered from the next state so it is glitch-free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cmdReady <= 1'b1;
    end else begin
      state    <= next_state;
      cmdReady <= (next_state == IDLE);
    end
  end

  // Divide-by-12 by repeated subtraction: one subtraction per cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem       <= '0;
      oct       <= '0;
      cur_voice <= '0;
    end else if (start) begin
      rem       <= cmdNote;
      oct       <= '0;
      cur_voice <= cmdVoice;
    end else if ((state == DIVIDE) && (rem >= NOTE_W'(12))) begin
      rem <= rem - NOTE_W'(12);
      oct <= oct + 4'd1;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    logic load_v;
    logic off_v;

    assign load_v = (state == LOAD) && (cur_voice == VOICE_W'(v));
    assign off_v  = stop && (cmdVoice == VOICE_W'(v));

    note_voice_counter #(
      .TICK_WIDTH(TICK_WIDTH)
    ) u_counter (
      .clk        (clk),
      .reset_n    (reset_n),
      .sample_tick(sampleTick),
      .load       (load_v),
      .load_ticks (load_ticks),
      .note_off   (off_v),
      .active     (voiceActive[v]),
      .square     (voiceSquare[v]),
      .toggle     (voiceEdge[v]),
      .ticks      (voiceTicks[v*TICK_WIDTH +: TICK_WIDTH])
    );
  end

endmodule

// File: tb/tb_note_tick_voices.sv
// tb/tb_note_tick_voices.sv - self-checking bench for note_tick_voices
module tb_note_tick_voices;

  localparam int NV = 4;
  localparam int TW = 24;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            sampleTick = 1'b0;
  logic            cmdValid = 1'b0;
  logic            cmdNoteOn = 1'b0;
  logic [1:0]      cmdVoice = '0;
  logic [6:0]      cmdNote = '0;
  logic            cmdReady;
  logic [NV-1:0]   voiceActive;
  logic [NV-1:0]   voiceSquare;
  logic [NV-1:0]   voiceEdge;
  logic [NV*TW-1:0] voiceTicks;

  logic            tick2 = 1'b0;
  logic            cmdValid2 = 1'b0;
  logic            cmdNoteOn2 = 1'b0;
  logic [1:0]      cmdVoice2 = '0;
  logic [6:0]      cmdNote2 = '0;
  logic            cmdReady2;
  logic [2:0]      act2;
  logic [2:0]      sq2;
  logic [2:0]      edge2;
  logic [3*TW-1:0] ticks2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_en = 0;
  int edge1_cnt = 0;

  always #5 clk = ~clk;

  note_tick_voices #(.NUM_VOICES(NV), .TICK_WIDTH(TW)) dut (
    .clk(clk), .reset_n(reset_n), .sampleTick(sampleTick),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdNoteOn(cmdNoteOn),
    .cmdVoice(cmdVoice), .cmdNote(cmdNote),
    .voiceActive(voiceActive), .voiceSquare(voiceSquare),
    .voiceEdge(voiceEdge), .voiceTicks(voiceTicks)
  );

  note_tick_voices #(.NUM_VOICES(3), .TICK_WIDTH(TW)) dut3 (
    .clk(clk), .reset_n(reset_n), .sampleTick(tick2),
    .cmdValid(cmdValid2), .cmdReady(cmdReady2), .cmdNoteOn(cmdNoteOn2),
    .cmdVoice(cmdVoice2), .cmdNote(cmdNote2),
    .voiceActive(act2), .voiceSquare(sq2),
    .voiceEdge(edge2), .voiceTicks(ticks2)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: busy time and period come straight from the note arithmetic
  int oct_tab[12] = '{23889, 22548, 21282, 20088, 18960, 17896,
                      16892, 15944, 15049, 14204, 13407, 12654};
  int m_period[NV];
  int m_phase[NV];
  bit m_active[NV];
  bit m_square[NV];
  bit m_edge[NV];
  int busy_cnt = 0;
  int pend_v = 0;
  int pend_per = 0;
  int load_v;
  int off_v;
  bit m_ready = 1;

  function automatic int period_of(input int n);
    return oct_tab[n % 12] >> (n / 12);
  endfunction

  initial begin
    for (int v = 0; v < NV; v++) begin
      m_period[v] = 0; m_phase[v] = 0; m_active[v] = 0; m_square[v] = 0; m_edge[v] = 0;
    end
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        busy_cnt = 0;
        m_ready  = 1;
        for (int v = 0; v < NV; v++) begin
          m_period[v] = 0; m_phase[v] = 0; m_active[v] = 0; m_square[v] = 0; m_edge[v] = 0;
        end
      end else begin
        load_v = -1;
        off_v  = -1;
        if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) load_v = pend_v;
        end else if (cmdValid) begin
          if (cmdNoteOn) begin
            busy_cnt = int'(cmdNote) / 12 + 2;
            pend_v   = int'(cmdVoice);
            pend_per = period_of(int'(cmdNote));
          end else begin
            off_v = int'(cmdVoice);
          end
        end
        for (int v = 0; v < NV; v++) begin
          m_edge[v] = 0;
          if (v == load_v) begin
            m_period[v] = pend_per; m_phase[v] = 0; m_square[v] = 0; m_active[v] = 1;
          end else if (v == off_v) begin
            m_active[v] = 0; m_square[v] = 0; m_phase[v] = 0;
          end else if (m_active[v] && sampleTick) begin
            if (m_phase[v] >= m_period[v] - 1) begin
              m_phase[v] = 0; m_square[v] = !m_square[v]; m_edge[v] = 1;
            end else begin
              m_phase[v]++;
            end
          end
        end
        m_ready = (busy_cnt == 0);
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (voiceEdge[1]) edge1_cnt++;
    if (cmp_en) begin
      chk("ready", cmdReady, m_ready);
      for (int v = 0; v < NV; v++) begin
        chk($sformatf("active%0d", v), voiceActive[v], m_active[v]);
        chk($sformatf("square%0d", v), voiceSquare[v], m_square[v]);
        chk($sformatf("edge%0d", v), voiceEdge[v], m_edge[v]);
        chk($sformatf("ticks%0d", v), voiceTicks[v*TW +: TW], m_period[v]);
      end
    end
  end

  // Sample strobe: 0 off/manual via tick_req, 1 every 4 clocks
  int   tick_mode = 0;
  logic tick_req = 1'b0;
  int   tcnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (tick_mode == 1) begin
        tcnt = (tcnt + 1) % 4;
        sampleTick = (tcnt == 0);
      end else begin
        sampleTick = tick_req;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic issue(input bit on, input int v, input int n, output int waited);
    waited = 0;
    cmdValid = 1'b1; cmdNoteOn = on; cmdVoice = 2'(v); cmdNote = 7'(n);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (cmdReady) begin
        @(posedge clk);
        #2;
        cmdValid = 1'b0;
        return;
      end
      waited++;
    end
    cmdValid = 1'b0;
    chk("accept_timeout", 0, 1);
  endtask

  task automatic busy_len(output int b);
    b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cmdReady) break;
      b++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_edge0(output int t, output bit sq);
    t = -1;
    sq = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (voiceEdge[0]) begin
        t = cyc;
        sq = voiceSquare[0];
        break;
      end
    end
    if (t < 0) chk("edge0_timeout", 0, 1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  int w, b, t1, t2, c0;
  bit s1, s2;

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("por_ready", cmdReady, 1);
    chk("por_active", voiceActive, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    step(1);
    chk("rst_ready", cmdReady, 1);
    chk("rst_square", voiceSquare, 0);
    chk("rst_ticks_zero", (voiceTicks == '0), 1);
    cmp_en = 1;
    tick_mode = 1;

    // Note 69 on voice 0
    issue(1, 0, 69, w);
    busy_len(b);
    chk("busy_69", b, 7);
    chk("ticks_69", voiceTicks[0 +: TW], 443);
    chk("model_69", m_period[0], 443);
    chk("active_69", voiceActive[0], 1);
    wait_edge0(t1, s1);
    wait_edge0(t2, s2);
    chk("edge_interval_clks", t2 - t1, 1772);
    chk("square_toggles", s2, !s1);

    // Extremes
    issue(1, 2, 0, w);
    busy_len(b);
    chk("busy_0", b, 2);
    chk("ticks_0", voiceTicks[2*TW +: TW], 23889);
    issue(1, 3, 127, w);
    busy_len(b);
    chk("busy_127", b, 12);
    chk("ticks_127", voiceTicks[3*TW +: TW], 15);
    chk("model_127", m_period[3], 15);
    issue(1, 2, 12, w);
    busy_len(b);
    chk("busy_12", b, 3);
    chk("ticks_12", voiceTicks[2*TW +: TW], 11944);

    // Backpressure: note-off for voice 0 held while voice 1 divides
    issue(1, 1, 127, w);
    issue(0, 0, 0, w);
    chk("bp_wait", w, 12);
    chk("bp_off_active", voiceActive[0], 0);
    chk("bp_off_square", voiceSquare[0], 0);
    chk("bp_v1_active", voiceActive[1], 1);
    chk("bp_v1_ticks", voiceTicks[1*TW +: TW], 15);
    issue(1, 0, 69, w);
    busy_len(b);

    // Coincidence: sample tick on the LOAD cycle of a voice 1 retrigger
    tick_mode = 0;
    tick_req = 1'b0;
    step(2);
    issue(1, 1, 127, w);
    step(11);
    chk("coin_on_load_cycle", busy_cnt, 1);
    tick_req = 1'b1;
    step(1);
    tick_req = 1'b0;
    step(1);
    chk("coin_v1_square", voiceSquare[1], 0);
    c0 = edge1_cnt;
    for (int i = 0; i < 14; i++) begin
      tick_req = 1'b1; step(1); tick_req = 1'b0; step(1);
    end
    chk("coin_no_edge_14", edge1_cnt - c0, 0);
    tick_req = 1'b1; step(1); tick_req = 1'b0; step(1);
    chk("coin_edge_15", edge1_cnt - c0, 1);
    chk("coin_square_15", voiceSquare[1], 1);

    // Reset in the middle of a divide
    tick_mode = 1;
    issue(1, 3, 100, w);
    step(2);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", cmdReady, 1);
    chk("mid_rst_active", voiceActive, 0);
    chk("mid_rst_square", voiceSquare, 0);
    chk("mid_rst_edge", voiceEdge, 0);
    chk("mid_rst_ticks_zero", (voiceTicks == '0), 1);
    @(posedge clk);
    #2 reset_n = 1'b1;
    step(1);
    busy_len(b);
    chk("post_rst_busy", b, 0);
    step(15);
    chk("post_rst_active", voiceActive, 0);

    // Three-voice instance: voice index 3 is out of range
    cmdValid2 = 1'b1; cmdNoteOn2 = 1'b1; cmdVoice2 = 2'd2; cmdNote2 = 7'd12;
    @(negedge clk);
    @(posedge clk);
    #2 cmdValid2 = 1'b0;
    step(4);
    chk("nv3_v2_ticks", ticks2[2*TW +: TW], 11944);
    chk("nv3_v2_active", act2, 3'b100);
    cmdValid2 = 1'b1; cmdVoice2 = 2'd3; cmdNote2 = 7'd60;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("nv3_ready", cmdReady2, 1);
      @(posedge clk);
      #2;
    end
    cmdValid2 = 1'b0;
    step(2);
    chk("nv3_active", act2, 3'b100);
    chk("nv3_square", sq2, 0);
    chk("nv3_ticks_v2", ticks2[2*TW +: TW], 11944);
    chk("nv3_ticks_low", ticks2[2*TW-1:0], 0);

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_tick_voices.md
# note_tick_voices

Parametrised multi-voice successor to the single-note MIDI-to-sample-ticks lookup. It accepts note-on and note-off commands through a valid/ready handshake. For each note it derives the half-period in sample ticks from a 12-entry octave table, using iterative divide-by-12 and a right shift. It then runs one phase counter per voice on the audio sample strobe. It sits between the MIDI parser and the voice mixer, and drives one square-wave/edge pair per voice.

## Interface
- NUM_VOICES, 4: number of independent voices (1..16).
- TICK_WIDTH, 24: width of period and phase counters (must be ≥15).
- VOICE_W, $clog2(NUM_VOICES) (min 1): width of voice index.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- sampleTick  in  1  one-cycle pulse at the audio sample rate.
- cmdValid  in  1  command present.
- cmdReady  out  1  block can accept a command.
- cmdNoteOn  in  1  1 = note-on, 0 = note-off.
- cmdVoice  in  VOICE_W  target voice.
- cmdNote  in  7  MIDI note number, 0..127.
- voiceActive  out  NUM_VOICES  voice is sounding.
- voiceSquare  out  NUM_VOICES  square wave, toggles every period.
- voiceEdge  out  NUM_VOICES  one-cycle pulse on each toggle.
- voiceTicks  out  NUM_VOICES*TICK_WIDTH  current half-period per voice; voice v occupies bits [v*TICK_WIDTH +: TICK_WIDTH].

## Operation
- Octave table, notes 0..11: 23889, 22548, 21282, 20088, 18960, 17896, 16892, 15944, 15049, 14204, 13407, 12654.
- Period for note n: table[n mod 12] >> (n div 12), truncating. Examples: note 69 → 443, note 127 → 15.
- A command is accepted on a clock edge where cmdValid && cmdReady.
- FSM states IDLE, DIVIDE, LOAD:
  - IDLE: cmdReady = 1.
  - Note-on to a valid voice: latch voice, set rem = note and oct = 0, go to DIVIDE.
  - Note-off to a valid voice: applied at the acceptance edge (active, square and phase cleared; voiceTicks held). State stays IDLE.
  - Command with cmdVoice ≥ NUM_VOICES: accepted and discarded. State stays IDLE.
- DIVIDE: if rem ≥ 12, then rem -= 12 and oct += 1; otherwise go to LOAD. Takes (n div 12)+1 cycles.
- LOAD: write voiceTicks[v], clear phase[v], clear square[v], set active[v]; return to IDLE. Note-on to an already-active voice is a retrigger with the same behaviour.
- Per-voice counter, on sampleTick while active:
  - If phase ≥ period−1: phase = 0, toggle square, pulse edge.
  - Otherwise: phase += 1.
  - The ≥ comparison handles a shortened period safely.
- Inactive voice: phase = 0, square = 0, edge = 0.

## Timing
- Reset values: cmdReady 1, voiceActive 0, voiceSquare 0, voiceEdge 0, voiceTicks 0, FSM IDLE.
- cmdReady is registered. After a note-on is accepted it is low for (n div 12)+2 cycles: note 0 → 2 cycles, note 69 → 7 cycles, note 127 → 12 cycles.
- Note-off takes effect on the outputs in the cycle after acceptance. cmdReady never drops for a note-off.
- A command held on cmdValid while cmdReady = 0 is not consumed; its fields must remain stable until accepted.
- voiceEdge pulses in the cycle after the terminal-count sampleTick, aligned with the voiceSquare change.
- sampleTick coincident with LOAD for voice v: LOAD wins, so phase[v] = 0 and that tick is not counted. Other voices count normally.
- reset_n low mid-DIVIDE or mid-LOAD: the command is aborted and all state returns to reset values immediately.

## Structure
- Package note_tick_pkg holds:
  - OCTAVE_TICKS, the 12-entry table (24-bit);
  - NOTE_W = 7;
  - the state enum {IDLE, DIVIDE, LOAD}.
- Sub-module note_voice_counter holds one voice's period register, phase counter, square and edge logic. It is instantiated NUM_VOICES times under a generate loop. The FSM and divider stay in the top level.

## Test plan
- Reset: assert reset_n = 0 mid-run. All outputs go to their reset values and cmdReady = 1 without waiting for a clock edge.
- Note-on, voice 0, note 69:
  - cmdReady low 7 cycles;
  - voiceTicks[0] = 443, voiceActive[0] = 1;
  - with sampleTick every 4 clocks, voiceEdge[0] every 443 ticks and voiceSquare[0] period 886 ticks.
- Extremes: note 0 → 23889, busy 2 cycles; note 127 → 15, busy 12 cycles; note 12 → 11944.
- Backpressure: issue a note-off for voice 0 while busy with voice 1. The note-off is held until cmdReady rises, then applied next cycle (voiceActive[0] = 0, voiceSquare[0] = 0). Voice 1 completes normally.
- Coincidence: sampleTick on the LOAD cycle of a voice 1 retrigger. Voice 1 phase = 0 and square = 0; voice 0 phase advances by 1.
- NUM_VOICES = 3, cmdVoice = 3 note-on: accepted with cmdReady staying 1, and no output changes.
